// File: rtl/deser_param.sv
// Serial-to-parallel deserializer for the UART receive path: gathers DATA_WIDTH
// strobed bits in a shadow register and commits whole words with parity.
module deser_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int LSB_FIRST      = 1,
    parameter int CLEAR_ON_ERROR = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          deser_en,
    input  logic                          sampled_bit,
    input  logic                          error_happened,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic                          data_valid,
    output logic                          par_bit,
    output logic                          busy,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shadow_p0;
    logic [DATA_WIDTH-1:0] word_next;

    function automatic logic word_parity(input logic [DATA_WIDTH-1:0] w);
        return ^w;
    endfunction

    // Arrival index cnt maps to bit cnt (LSB first) or DATA_WIDTH-1-cnt (MSB first).
    function automatic logic [DATA_WIDTH-1:0] place_bit(input logic [DATA_WIDTH-1:0] w,
                                                        input logic [CNT_W-1:0]      cnt,
                                                        input logic                  b);
        logic [DATA_WIDTH-1:0] r;
        int                    pos;
        r   = w;
        pos = (LSB_FIRST != 0) ? int'(cnt) : (DATA_WIDTH - 1 - int'(cnt));
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == pos) r[i] = b;
        end
        return r;
    endfunction

    assign word_next = place_bit(shadow_p0, bit_cnt, sampled_bit);
    assign busy      = (state == COLLECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow_p0  <= '0;
            bit_cnt    <= '0;
            P_DATA     <= '0;
            par_bit    <= 1'b0;
            data_valid <= 1'b0;
        end else if (error_happened) begin
            state      <= IDLE;
            shadow_p0  <= '0;
            bit_cnt    <= '0;
            data_valid <= 1'b0;
            if (CLEAR_ON_ERROR != 0) begin
                P_DATA  <= '0;
                par_bit <= 1'b0;
            end
        end else if (deser_en) begin
            if (bit_cnt == LAST_CNT) begin
                // Final bit: commit the shadow plus this bit straight to the output.
                P_DATA     <= word_next;
                par_bit    <= word_parity(word_next);
                data_valid <= 1'b1;
                shadow_p0  <= '0;
                bit_cnt    <= '0;
                state      <= IDLE;
            end else begin
                shadow_p0  <= word_next;
                bit_cnt    <= bit_cnt + CNT_W'(1);
                data_valid <= 1'b0;
                state      <= COLLECT;
            end
        end else begin
            data_valid <= 1'b0;
        end
    end

endmodule
